// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default widths, butterfly latency,
// a complex sample type and the round/saturate helpers used by the
// butterfly output scaler lanes.
package fft_pkg;

    localparam int DATA_WIDTH = 27;
    localparam int TWID_WIDTH = 16;
    localparam int SHIFT      = 15;
    localparam int BF_LATENCY = 4;

    // Working width of the helpers; wide enough that the rounding add
    // never wraps for any supported input width (up to 63 bits).
    localparam int CALC_W = 64;

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic                     sat;
        logic signed [CALC_W-1:0] value;
    } sat_res_t;

    // Arithmetic right shift by 'shift' with round-half-up.
    function automatic logic signed [CALC_W-1:0] round_shift(
        input logic signed [CALC_W-1:0] y,
        input int                       shift
    );
        logic signed [CALC_W-1:0] half;
        half = '0;
        if (shift > 0) begin
            half = 64'sd1 <<< (shift - 1);
        end
        return (y + half) >>> shift;
    endfunction

    // Clamp r to the signed range of 'width' bits; sat flags a clamp.
    function automatic sat_res_t sat_to_width(
        input logic signed [CALC_W-1:0] r,
        input int                       width
    );
        sat_res_t                 res;
        logic signed [CALC_W-1:0] max_v;
        logic signed [CALC_W-1:0] min_v;
        max_v     = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v     = -(64'sd1 <<< (width - 1));
        res.sat   = 1'b0;
        res.value = r;
        if (r > max_v) begin
            res.sat   = 1'b1;
            res.value = max_v;
        end else if (r < min_v) begin
            res.sat   = 1'b1;
            res.value = min_v;
        end
        return res;
    endfunction

endpackage

// File: rtl/bf_scaler_lane.sv
// One scaling lane: register 1 holds the rounded/shifted value, register 2
// holds the saturated DATA_WIDTH result. sat_flag is the saturation decision
// for the value currently in register 1, i.e. the one about to be output.
module bf_scaler_lane
    import fft_pkg::*;
#(
    parameter int IN_WIDTH  = 44,
    parameter int OUT_WIDTH = 27,
    parameter int SHIFT_AMT = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en_p0,
    input  logic                        en_p1,
    input  logic signed [IN_WIDTH-1:0]  y,
    output logic signed [OUT_WIDTH-1:0] z,
    output logic                        sat_flag
);

    logic signed [IN_WIDTH-1:0] r_p1;
    sat_res_t                   sat_res;

    // Round stage: load only for a valid sample so values hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1 <= '0;
        end else if (en_p0) begin
            r_p1 <= IN_WIDTH'(round_shift(CALC_W'(y), SHIFT_AMT));
        end
    end

    // Saturation decision on the rounded value.
    always_comb begin
        sat_res = sat_to_width(CALC_W'(r_p1), OUT_WIDTH);
    end

    assign sat_flag = sat_res.sat;

    // Saturate stage: output register, held while no valid pair advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z <= '0;
        end else if (en_p1) begin
            z <= sat_res.value[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/bf_output_scaler.sv
// Butterfly output scaler: rounds and saturates the four full-precision
// butterfly outputs back to DATA_WIDTH, aligns the valid tag with the
// butterfly latency, marks the last pair of each frame and keeps a sticky
// overflow flag. Optional macro BF_SCALER_STATS_EN adds a 16-bit saturating
// count of output pairs with at least one saturated lane (sat_count).
module bf_output_scaler
    import fft_pkg::*;
#(
    parameter int  DATA_WIDTH  = fft_pkg::DATA_WIDTH,
    parameter int  TWID_WIDTH  = fft_pkg::TWID_WIDTH,
    parameter int  SHIFT       = fft_pkg::SHIFT,
    parameter int  BF_LATENCY  = fft_pkg::BF_LATENCY,
    parameter int  FRAME_PAIRS = 512,
    localparam int IN_WIDTH    = DATA_WIDTH + TWID_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         bf_in_valid,
    input  logic signed [IN_WIDTH-1:0]   yp_r,
    input  logic signed [IN_WIDTH-1:0]   yp_i,
    input  logic signed [IN_WIDTH-1:0]   yq_r,
    input  logic signed [IN_WIDTH-1:0]   yq_i,
    input  logic                         clr_ovf,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] zp_r,
    output logic signed [DATA_WIDTH-1:0] zp_i,
    output logic signed [DATA_WIDTH-1:0] zq_r,
    output logic signed [DATA_WIDTH-1:0] zq_i,
    output logic                         frame_last,
    output logic                         ovf_sticky
`ifdef BF_SCALER_STATS_EN
    ,
    output logic [15:0]                  sat_count
`endif
);

    localparam int CNT_W = (FRAME_PAIRS > 1) ? $clog2(FRAME_PAIRS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PAIRS - 1);

    logic [BF_LATENCY-1:0] vld_dly;
    logic                  vld_p0;
    logic                  vld_p1;
    logic [3:0]            sat_lane;
    logic                  sat_any_p1;
    logic [CNT_W-1:0]      cnt;

    // Valid delay line matching the butterfly latency; shifts every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_dly <= '0;
        end else begin
            vld_dly[0] <= bf_in_valid;
            for (int i = 1; i < BF_LATENCY; i++) begin
                vld_dly[i] <= vld_dly[i-1];
            end
        end
    end

    assign vld_p0 = vld_dly[BF_LATENCY-1];

    // Valid tag following the round and saturate registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            vld_p1    <= vld_p0;
            out_valid <= vld_p1;
        end
    end

    bf_scaler_lane #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(DATA_WIDTH), .SHIFT_AMT(SHIFT)) u_lane_pr (
        .clk(clk), .rst_n(rst_n), .en_p0(vld_p0), .en_p1(vld_p1),
        .y(yp_r), .z(zp_r), .sat_flag(sat_lane[0])
    );

    bf_scaler_lane #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(DATA_WIDTH), .SHIFT_AMT(SHIFT)) u_lane_pi (
        .clk(clk), .rst_n(rst_n), .en_p0(vld_p0), .en_p1(vld_p1),
        .y(yp_i), .z(zp_i), .sat_flag(sat_lane[1])
    );

    bf_scaler_lane #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(DATA_WIDTH), .SHIFT_AMT(SHIFT)) u_lane_qr (
        .clk(clk), .rst_n(rst_n), .en_p0(vld_p0), .en_p1(vld_p1),
        .y(yq_r), .z(zq_r), .sat_flag(sat_lane[2])
    );

    bf_scaler_lane #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(DATA_WIDTH), .SHIFT_AMT(SHIFT)) u_lane_qi (
        .clk(clk), .rst_n(rst_n), .en_p0(vld_p0), .en_p1(vld_p1),
        .y(yq_i), .z(zq_i), .sat_flag(sat_lane[3])
    );

    // Saturation only counts for a pair that is actually advancing to the output.
    assign sat_any_p1 = vld_p1 & (|sat_lane);

    // Frame position counter and registered last-pair marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            frame_last <= 1'b0;
        end else begin
            frame_last <= vld_p1 && (cnt == CNT_LAST);
            if (vld_p1) begin
                if (cnt == CNT_LAST) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Sticky overflow: a saturating pair wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (sat_any_p1) begin
            ovf_sticky <= 1'b1;
        end else if (clr_ovf) begin
            ovf_sticky <= 1'b0;
        end
    end

`ifdef BF_SCALER_STATS_EN
    // Saturating count of pairs with a clamped lane; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (clr_ovf) begin
            sat_count <= '0;
        end else if (sat_any_p1 && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bf_output_scaler.sv
// Directed bench for bf_output_scaler (FRAME_PAIRS=4). A small delay line
// stands in for the butterfly so y* arrives 4 cycles after bf_in_valid.
module tb_bf_output_scaler;

    localparam int DW = 27;
    localparam int IW = 44;
    localparam int FP = 4;

    localparam logic signed [IW-1:0] P41 = 44'sd1 <<< 41;
    localparam logic signed [IW-1:0] P42 = 44'sd1 <<< 42;
    localparam logic [DW-1:0] ZMAX = 27'h3FFFFFF;
    localparam logic [DW-1:0] ZMIN = 27'h4000000;

    logic                 clk;
    logic                 rst_n;
    logic                 bf_in_valid;
    logic                 clr_ovf;
    logic signed [IW-1:0] yp_r, yp_i, yq_r, yq_i;
    logic                 out_valid;
    logic signed [DW-1:0] zp_r, zp_i, zq_r, zq_i;
    logic                 frame_last;
    logic                 ovf_sticky;
`ifdef BF_SCALER_STATS_EN
    logic [15:0]          sat_count;
`endif

    logic signed [IW-1:0] src_pr, src_pi, src_qr, src_qi;
    logic signed [IW-1:0] pipe_pr [4];
    logic signed [IW-1:0] pipe_pi [4];
    logic signed [IW-1:0] pipe_qr [4];
    logic signed [IW-1:0] pipe_qi [4];

    int n_vec;
    int n_bad;

    bf_output_scaler #(.FRAME_PAIRS(FP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bf_in_valid(bf_in_valid),
        .yp_r       (yp_r),
        .yp_i       (yp_i),
        .yq_r       (yq_r),
        .yq_i       (yq_i),
        .clr_ovf    (clr_ovf),
        .out_valid  (out_valid),
        .zp_r       (zp_r),
        .zp_i       (zp_i),
        .zq_r       (zq_r),
        .zq_i       (zq_i),
        .frame_last (frame_last),
        .ovf_sticky (ovf_sticky)
`ifdef BF_SCALER_STATS_EN
        ,
        .sat_count  (sat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Butterfly stand-in: 4-cycle data delay.
    always @(posedge clk) begin
        pipe_pr[0] <= src_pr;
        pipe_pi[0] <= src_pi;
        pipe_qr[0] <= src_qr;
        pipe_qi[0] <= src_qi;
        for (int i = 1; i < 4; i++) begin
            pipe_pr[i] <= pipe_pr[i-1];
            pipe_pi[i] <= pipe_pi[i-1];
            pipe_qr[i] <= pipe_qr[i-1];
            pipe_qi[i] <= pipe_qi[i-1];
        end
    end

    assign yp_r = pipe_pr[3];
    assign yp_i = pipe_pi[3];
    assign yq_r = pipe_qr[3];
    assign yq_i = pipe_qi[3];

    function automatic logic [63:0] zx(input logic [DW-1:0] v);
        return {37'd0, v};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_z(input string tag, input logic [DW-1:0] epr, input logic [DW-1:0] epi,
                         input logic [DW-1:0] eqr, input logic [DW-1:0] eqi);
        chk({tag, ".zp_r"}, zx(zp_r), zx(epr));
        chk({tag, ".zp_i"}, zx(zp_i), zx(epi));
        chk({tag, ".zq_r"}, zx(zq_r), zx(eqr));
        chk({tag, ".zq_i"}, zx(zq_i), zx(eqi));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [IW-1:0] pr, input logic signed [IW-1:0] pi,
                        input logic signed [IW-1:0] qr, input logic signed [IW-1:0] qi);
        src_pr      = pr;
        src_pi      = pi;
        src_qr      = qr;
        src_qi      = qi;
        bf_in_valid = 1'b1;
        tick(1);
        bf_in_valid = 1'b0;
    endtask

    initial begin
        n_vec       = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        bf_in_valid = 1'b0;
        clr_ovf     = 1'b0;
        src_pr      = '0;
        src_pi      = '0;
        src_qr      = '0;
        src_qi      = '0;
        tick(2);

        // Reset state
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.frame_last", frame_last, 1'b0);
        chk("rst.ovf", ovf_sticky, 1'b0);
        chk_z("rst", 27'd0, 27'd0, 27'd0, 27'd0);
`ifdef BF_SCALER_STATS_EN
        chk("rst.sat_count", sat_count, 16'd0);
`endif
        rst_n = 1'b1;
        tick(1);

        // T1/T2: basic scaling and rounding, two back-to-back pairs
        send(44'sd32768, 44'sd16384, 44'sd16383, -44'sd16384);
        send(-44'sd16385, 44'sd0, 44'sd49152, -44'sd49153);
        tick(3);
        chk("t1.early_valid", out_valid, 1'b0);
        tick(1);
        chk("t1.valid_a", out_valid, 1'b1);
        chk_z("t1.a", 27'd1, 27'd1, 27'd0, 27'd0);
        chk("t1.fl_a", frame_last, 1'b0);
        chk("t1.ovf_a", ovf_sticky, 1'b0);
        tick(1);
        chk("t2.valid_b", out_valid, 1'b1);
        chk_z("t2.b", 27'h7FFFFFF, 27'd0, 27'd2, 27'h7FFFFFE);
        tick(1);
        chk("t2.valid_off", out_valid, 1'b0);
        chk_z("t2.hold", 27'h7FFFFFF, 27'd0, 27'd2, 27'h7FFFFFE);

        // T3: range boundaries (no saturation) then saturation on pair D (4th -> frame_last)
        send(P41 - 44'sd32768, -P41, P41 - 44'sd16385, -P41 - 44'sd16384);
        send(P41, -P42, 44'sd229376, -44'sd98304);
        tick(4);
        chk("t3.valid_c", out_valid, 1'b1);
        chk_z("t3.c", ZMAX, ZMIN, ZMAX, ZMIN);
        chk("t3.ovf_c", ovf_sticky, 1'b0);
        chk("t3.fl_c", frame_last, 1'b0);
        tick(1);
        chk_z("t3.d", ZMAX, ZMIN, 27'd7, 27'h7FFFFFD);
        chk("t3.ovf_d", ovf_sticky, 1'b1);
        chk("t3.fl_d", frame_last, 1'b1);
`ifdef BF_SCALER_STATS_EN
        chk("t3.sat_count", sat_count, 16'd1);
`endif
        tick(1);
        chk("t3.fl_off", frame_last, 1'b0);
        chk("t3.ovf_hold", ovf_sticky, 1'b1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        chk("t3.ovf_clr", ovf_sticky, 1'b0);
`ifdef BF_SCALER_STATS_EN
        chk("t3.sat_count_clr", sat_count, 16'd0);
`endif

        // T3: saturation coincident with clr_ovf; extreme inputs must not wrap
        send(44'sh7FFFFFFFFFF, 44'sh80000000000, 44'sd0, 44'sd0);
        tick(4);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        chk("t3.valid_e", out_valid, 1'b1);
        chk_z("t3.e", ZMAX, ZMIN, 27'd0, 27'd0);
        chk("t3.ovf_set_wins", ovf_sticky, 1'b1);
        chk("t3.fl_e", frame_last, 1'b0);
`ifdef BF_SCALER_STATS_EN
        chk("t3.sat_count_clr_wins", sat_count, 16'd0);
`endif

        // T5: asynchronous reset with three pairs in flight
        send(44'sd32768, 44'sd32768, 44'sd32768, 44'sd32768);
        send(44'sd65536, 44'sd65536, 44'sd65536, 44'sd65536);
        send(P41, P41, P41, P41);
        rst_n = 1'b0;
        #1;
        chk("t5.async_valid", out_valid, 1'b0);
        chk("t5.async_ovf", ovf_sticky, 1'b0);
        chk("t5.async_fl", frame_last, 1'b0);
        chk_z("t5.async", 27'd0, 27'd0, 27'd0, 27'd0);
        tick(1);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            chk("t5.no_valid", out_valid, 1'b0);
        end
        chk("t5.ovf_after", ovf_sticky, 1'b0);

        // T4: 10 back-to-back pairs, frame_last on outputs 4 and 8
        for (int c = 0; c < 16; c++) begin
            int k;
            bf_in_valid = (c < 10);
            src_pr      = IW'(c) <<< 15;
            src_pi      = -(IW'(c) <<< 15);
            src_qr      = '0;
            src_qi      = '0;
            tick(1);
            k = c + 1 - 6;
            if (k >= 0 && k < 10) begin
                chk("t4.valid", out_valid, 1'b1);
                chk("t4.zp_r", zx(zp_r), zx(DW'(k)));
                chk("t4.zp_i", zx(zp_i), zx(DW'(-k)));
                chk("t4.frame_last", frame_last, (k % 4) == 3);
            end else begin
                chk("t4.idle", out_valid, 1'b0);
            end
        end
        bf_in_valid = 1'b0;

        // T4: counter sits at 2; two more pairs with a gap -> second one is last
        send(44'sd32768, 44'sd0, 44'sd0, 44'sd0);
        tick(5);
        chk("t4.gap_valid_11", out_valid, 1'b1);
        chk("t4.gap_fl_11", frame_last, 1'b0);
        tick(1);
        send(44'sd65536, 44'sd0, 44'sd0, 44'sd0);
        tick(5);
        chk("t4.gap_valid_12", out_valid, 1'b1);
        chk("t4.gap_fl_12", frame_last, 1'b1);
        chk("t4.gap_z_12", zx(zp_r), zx(27'd2));

`ifdef BF_SCALER_STATS_EN
        // T6: three saturating pairs, then clear
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        send(P41, 44'sd0, 44'sd0, 44'sd0);
        send(44'sd0, -P42, 44'sd0, 44'sd0);
        send(P41, P41, P41, P41);
        tick(5);
        chk("t6.sat_count3", sat_count, 16'd3);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        chk("t6.sat_count0", sat_count, 16'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
